// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one synchronous FIFO write port among
//            NUM_REQ valid/ready requesters. An owner keeps the grant for at
//            most BURST_LEN accepted beats or until it drops valid. Writes are
//            gated by fifo_full, so arbitrated traffic never overflows the FIFO.
//            Optional per-requester beat statistics: FIFO_WR_ARB_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ID   = 2,
    parameter int WIDTH_DATA = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                             sys_clk,
    input  logic                             srst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_wr_en,
    output logic [WIDTH_DATA-1:0]            fifo_wr_data,
    output logic [WIDTH_ID-1:0]              grant_id,
    output logic                             arb_busy
`ifdef FIFO_WR_ARB_STAT_EN
    ,
    input  logic                             stat_clr,
    output logic [NUM_REQ*16-1:0]            stat_beats
`endif
);

    localparam logic [0:0]          S_IDLE        = 1'b0;
    localparam logic [0:0]          S_GRANT       = 1'b1;
    localparam logic [3:0]          c_last_beat   = 4'(BURST_LEN - 1);
    localparam logic [WIDTH_ID-1:0] c_last_id     = WIDTH_ID'(NUM_REQ - 1);
    localparam logic [WIDTH_ID:0]   c_num_req_ext = (WIDTH_ID + 1)'(NUM_REQ);

    logic [0:0]            r_fsm,      w_fsm_nxt;
    logic [WIDTH_ID-1:0]   r_owner,    w_owner_nxt;
    logic [WIDTH_ID-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [3:0]            r_beat_cnt, w_beat_cnt_nxt;

    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_ready;
    logic [NUM_REQ-1:0]    w_beat;
    logic                  w_xfer;
    logic [WIDTH_DATA-1:0] w_owner_data;
    logic                  w_owner_valid;
    logic [WIDTH_ID-1:0]   w_owner_inc;
    logic [WIDTH_ID-1:0]   w_search_start;
    logic [WIDTH_ID:0]     w_cand;
    logic                  w_found;
    logic [WIDTH_ID-1:0]   w_winner;
    logic                  w_release;

    assign w_grant     = (r_fsm == S_GRANT);
    assign w_owner_inc = (r_owner == c_last_id) ? '0 : r_owner + 1'b1;
    // While granted the next search always begins just past the current owner,
    // which is also what rr_ptr becomes on release.
    assign w_search_start = w_grant ? w_owner_inc : r_rr_ptr;

    // Only the owner sees ready, and never while full or during reset.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_grant && (r_owner == WIDTH_ID'(i)) && !fifo_full && !srst;
        end
    end

    assign w_beat = req_valid & w_ready;
    assign w_xfer = |w_beat;

    // Select the owner's data slice and valid bit (one-hot compare keeps
    // out-of-range owner codes harmless).
    always_comb begin
        w_owner_data  = '0;
        w_owner_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == WIDTH_ID'(i)) begin
                w_owner_data  = req_data[i*WIDTH_DATA +: WIDTH_DATA];
                w_owner_valid = req_valid[i];
            end
        end
    end

    // Cyclic first-valid search from w_search_start; scanning offsets from the
    // top down lets the smallest offset overwrite any later hits.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, w_search_start} + (WIDTH_ID + 1)'(k);
            if (w_cand >= c_num_req_ext) begin
                w_cand = w_cand - c_num_req_ext;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((w_cand == (WIDTH_ID + 1)'(j)) && req_valid[j]) begin
                    w_found  = 1'b1;
                    w_winner = WIDTH_ID'(j);
                end
            end
        end
    end

    // Burst ends on the last accepted beat, or as soon as the owner drops valid.
    assign w_release = (w_xfer && (r_beat_cnt == c_last_beat)) || !w_owner_valid;

    // Next-state logic: grant on request, back-to-back handover on release.
    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        if (r_fsm == S_IDLE) begin
            if (w_found) begin
                w_fsm_nxt      = S_GRANT;
                w_owner_nxt    = w_winner;
                w_beat_cnt_nxt = 4'd0;
            end
        end else begin
            if (w_release) begin
                w_rr_ptr_nxt = w_owner_inc;
                if (w_found) begin
                    w_owner_nxt    = w_winner;
                    w_beat_cnt_nxt = 4'd0;
                end else begin
                    w_fsm_nxt = S_IDLE;
                end
            end else if (w_xfer) begin
                w_beat_cnt_nxt = r_beat_cnt + 4'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (srst) begin
            r_fsm      <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= 4'd0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    assign req_ready    = w_ready;
    assign fifo_wr_en   = w_xfer;
    assign fifo_wr_data = w_xfer ? w_owner_data : '0;
    assign grant_id     = w_grant ? r_owner : '0;
    assign arb_busy     = w_grant;

`ifdef FIFO_WR_ARB_STAT_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [15:0] r_stat;
        // Saturating accepted-beat counter; a clear beats a coincident beat.
        always_ff @(posedge sys_clk) begin
            if (srst || stat_clr) begin
                r_stat <= 16'd0;
            end else if (w_beat[gi] && (r_stat != 16'hFFFF)) begin
                r_stat <= r_stat + 16'd1;
            end
        end
        assign stat_beats[gi*16 +: 16] = r_stat;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Self-checking bench for fifo_wr_arbiter: directed scenarios plus
//            randomized traffic against a cycle-level reference model and a
//            depth-8 FIFO occupancy model driving fifo_full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int WID   = 2;
    localparam int WD    = 8;
    localparam int BL    = 4;
    localparam int DEPTH = 8;

    logic              sys_clk = 1'b0;
    logic              srst;
    logic [N-1:0]      req_valid;
    logic [N*WD-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [WD-1:0]     fifo_wr_data;
    logic [WID-1:0]    grant_id;
    logic              arb_busy;
`ifdef FIFO_WR_ARB_STAT_EN
    logic              stat_clr;
    logic [N*16-1:0]   stat_beats;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ(N), .WIDTH_ID(WID), .WIDTH_DATA(WD), .BURST_LEN(BL)
    ) dut (
        .sys_clk      (sys_clk),
        .srst         (srst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy)
`ifdef FIFO_WR_ARB_STAT_EN
        ,
        .stat_clr     (stat_clr),
        .stat_beats   (stat_beats)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus state
    int        remaining [N];
    logic [7:0] seq      [N];
    int        p_valid, p_read, p_srst, p_clr;
    int        fifo_cnt, full_force, clr_hold;
    bit        srst_req, arm_full, arm_rst;

    // Observed write log
    int wr_id_q[$];
    int wr_dat_q[$];
    int nwr_r [N];

    // Reference model state
    bit m_busy;
    int m_owner, m_ptr, m_beats;
    int m_stat [N];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_winner(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        if (arm_full && nwr_r[2] == 2) begin
            full_force = 5;
            arm_full   = 1'b0;
        end
        srst = srst_req || (p_srst > 0 && $urandom_range(999) < p_srst);
        srst_req = 1'b0;
        if (arm_rst && nwr_r[3] == 1) begin
            srst         = 1'b1;
            remaining[0] = 2;
            arm_rst      = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (remaining[i] > 0) && ($urandom_range(99) < p_valid);
            req_data[i*WD +: WD] = seq[i];
        end
        fifo_full = (full_force > 0) || (fifo_cnt >= DEPTH);
`ifdef FIFO_WR_ARB_STAT_EN
        stat_clr = (clr_hold > 0) || (p_clr > 0 && $urandom_range(999) < p_clr);
`endif
    endtask

    task automatic cycle();
        logic [N-1:0]  e_rdy;
        logic          e_wr;
        logic [WD-1:0] e_data;
        int            w;
        bit            rd;
        drive();
        @(negedge sys_clk);
        for (int i = 0; i < N; i++)
            e_rdy[i] = m_busy && (m_owner == i) && !fifo_full && !srst;
        e_wr   = m_busy && req_valid[m_owner] && e_rdy[m_owner];
        e_data = e_wr ? seq[m_owner] : '0;
        check_val("req_ready", 64'(req_ready), 64'(e_rdy));
        check_val("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
        check_val("fifo_wr_data", 64'(fifo_wr_data), 64'(e_data));
        check_val("grant_id", 64'(grant_id), 64'(m_busy ? m_owner : 0));
        check_val("arb_busy", 64'(arb_busy), 64'(m_busy));
        check_val("wr_while_full", 64'(fifo_wr_en & fifo_full), 64'(0));
`ifdef FIFO_WR_ARB_STAT_EN
        begin
            logic [N*16-1:0] e_stat;
            for (int i = 0; i < N; i++) e_stat[i*16 +: 16] = 16'(m_stat[i]);
            check_val("stat_beats", 64'(stat_beats), 64'(e_stat));
        end
`endif
        if (fifo_wr_en) begin
            wr_id_q.push_back(int'(grant_id));
            wr_dat_q.push_back(int'(fifo_wr_data));
            nwr_r[grant_id]++;
        end
        @(posedge sys_clk);
        // Requester, statistics and FIFO bookkeeping
        for (int i = 0; i < N; i++) begin
`ifdef FIFO_WR_ARB_STAT_EN
            if (srst || stat_clr) m_stat[i] = 0;
            else if (e_wr && m_owner == i && m_stat[i] < 65535) m_stat[i]++;
`endif
        end
        if (e_wr) begin
            remaining[m_owner]--;
            seq[m_owner]++;
        end
        rd = (fifo_cnt > 0) && ($urandom_range(99) < p_read);
        fifo_cnt = fifo_cnt + (e_wr ? 1 : 0) - (rd ? 1 : 0);
        if (full_force > 0) full_force--;
        if (clr_hold > 0) clr_hold--;
        // Arbitration rules
        if (srst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            w = find_winner(m_ptr, req_valid);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_beats = 0;
            end
        end else if ((e_wr && m_beats == BL - 1) || !req_valid[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            w = find_winner(m_ptr, req_valid);
            if (w >= 0) begin
                m_owner = w; m_beats = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else if (e_wr) begin
            m_beats++;
        end
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            nwr_r[i]     = 0;
        end
        full_force = 0;
        fifo_cnt   = 0;
        srst_req   = 1'b1;
        cycle();
        wr_id_q.delete();
        wr_dat_q.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0; nwr_r[i] = 0; m_stat[i] = 0;
            seq[i] = 8'(i * 64);
        end
        p_valid = 100; p_read = 100; p_srst = 0; p_clr = 0;
        fifo_cnt = 0; full_force = 0; clr_hold = 0;
        arm_full = 1'b0; arm_rst = 1'b0; srst_req = 1'b1;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
        req_valid = '0; req_data = '0; fifo_full = 1'b0; srst = 1'b1;
`ifdef FIFO_WR_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        @(posedge sys_clk);
        #1;
        srst_req = 1'b0;

        // Reset state, then a single requester with three beats
        cycle();
        remaining[1] = 3;
        seq[1]       = 8'hA1;
        repeat (7) cycle();
        check_val("single_count", 64'(wr_dat_q.size()), 64'(3));
        for (int k = 0; k < 3 && k < wr_dat_q.size(); k++) begin
            check_val("single_data", 64'(wr_dat_q[k]), 64'(8'hA1 + k));
            check_val("single_id", 64'(wr_id_q[k]), 64'(1));
        end

        // All requesters busy: 4-beat bursts in order 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++) remaining[i] = 8;
        repeat (40) cycle();
        check_val("rr_count", 64'(wr_id_q.size()), 64'(32));
        for (int k = 0; k < 32 && k < wr_id_q.size(); k++)
            check_val("rr_order", 64'(wr_id_q[k]), 64'((k / 4) % 4));

        // Backpressure mid-burst of requester 2, then handover to 3
        do_reset();
        remaining[2] = 4; remaining[3] = 4; arm_full = 1'b1;
        repeat (20) cycle();
        check_val("full_count", 64'(wr_id_q.size()), 64'(8));
        for (int k = 0; k < 8 && k < wr_id_q.size(); k++)
            check_val("full_order", 64'(wr_id_q[k]), 64'(k < 4 ? 2 : 3));

        // FIFO depth 8 from empty, no reads: exactly 8 writes accepted
        do_reset();
        p_read = 0;
        remaining[0] = 20;
        repeat (30) cycle();
        check_val("depth_writes", 64'(wr_dat_q.size()), 64'(DEPTH));
        check_val("depth_ready_low", 64'(req_ready), 64'(0));
        p_read = 50;
        repeat (80) cycle();
        check_val("depth_total", 64'(wr_dat_q.size()), 64'(20));
        p_read = 100;

        // Reset during requester 3's second beat; arbitration restarts at 0
        do_reset();
        remaining[3] = 4; arm_rst = 1'b1;
        repeat (15) cycle();
        check_val("srst_count", 64'(wr_id_q.size()), 64'(6));
        for (int k = 0; k < 6 && k < wr_id_q.size(); k++)
            check_val("srst_order", 64'(wr_id_q[k]), 64'((k == 1 || k == 2) ? 0 : 3));

`ifdef FIFO_WR_ARB_STAT_EN
        // Statistics: 10 beats, then a clear that coincides with one beat
        do_reset();
        remaining[1] = 10;
        repeat (16) cycle();
        check_val("stat_ten", 64'(stat_beats), 64'(10) << 16);
        remaining[1] = 1;
        clr_hold = 2;
        repeat (4) cycle();
        check_val("stat_clr_win", 64'(stat_beats), 64'(0));
        check_val("stat_clr_beat", 64'(wr_dat_q.size()), 64'(11));
`endif

        // Randomized traffic, backpressure, resets and clears
        do_reset();
        p_valid = 75; p_read = 45; p_srst = 4; p_clr = 3;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (remaining[i] == 0 && $urandom_range(99) < 10)
                    remaining[i] = int'($urandom_range(12, 1));
            if (full_force == 0 && $urandom_range(99) < 3)
                full_force = int'($urandom_range(4, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port between Num_req independent requesters.
- Each requester has a valid/ready handshake. The arbiter grants one owner at a time for a bounded burst, and forwards the owner's beats to fifo_wr_en/fifo_wr_data.
- Writes are never issued while fifo_full is high, so the FIFO's fifo_wr_err can never fire from arbitrated traffic.
- Sits directly in front of the synchronous FIFO, on the same clock.

Parameters:
- Num_req, 4, number of requesters (2..8).
- Width_id, 2, width of the grant index; must satisfy 2^Width_id >= Num_req.
- Width_data, 8, data width; matches the FIFO write data width.
- Burst_len, 4, maximum accepted beats per grant (1..16).

Ports:
- sys_clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- req_valid  in  Num_req  per-requester data valid.
- req_data  in  Num_req*Width_data  requester i occupies bits [i*Width_data +: Width_data].
- req_ready  out  Num_req  per-requester accept; a beat transfers when valid & ready are both high.
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  Width_data  FIFO write data.
- grant_id  out  Width_id  current owner index; 0 when idle.
- arb_busy  out  1  high while in state GRANT.

Behaviour:
- Registered state: fsm (IDLE/GRANT), owner (Width_id), rr_ptr (Width_id), beat_cnt (4 bits).
- Reset values: fsm=IDLE, owner=0, rr_ptr=0, beat_cnt=0. All outputs are therefore 0 after reset.
- srst asserted mid-burst: takes effect at the next edge. During the srst cycle req_ready and fifo_wr_en are forced to 0, so no beat transfers in that cycle.
- Combinational outputs:
  - req_ready[i] = (fsm==GRANT) & (owner==i) & ~fifo_full & ~srst.
  - fifo_wr_en = |(req_valid & req_ready).
  - fifo_wr_data = req_data slice of owner; don't-care value is driven 0 when fifo_wr_en is low.
  - grant_id = owner when in GRANT, else 0.
  - arb_busy = (fsm==GRANT).
- Winner search: the first index j with req_valid[j]=1, scanning cyclically from rr_ptr upward (mod Num_req).
- IDLE:
  - If any req_valid is high, go to GRANT with owner = winner and beat_cnt = 0. Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: a request first seen in cycle t can transfer in cycle t+1 at the earliest.
- GRANT, release conditions:
  - (a) accepted beat with beat_cnt == Burst_len-1, or
  - (b) req_valid[owner] == 0.
- GRANT, on release:
  - rr_ptr <= owner+1 mod Num_req.
  - If some req_valid is high (search starting from owner+1), stay in GRANT with the new winner and beat_cnt = 0. This gives back-to-back handover with no idle cycle.
  - Otherwise go to IDLE.
  - The previous owner may win again only if it is the sole requester.
- GRANT, accepted beat without release: beat_cnt increments.
- fifo_full high: no transfer, beat_cnt frozen, owner held. The grant is never revoked for backpressure; release (b) still applies.
- Full/write race: the FIFO's registered flag already predicts full, so gating by fifo_full alone is sufficient. Exactly Depth writes are accepted from empty.
- Num_req not a power of two: rr_ptr wraps from Num_req-1 to 0; indices >= Num_req are never granted.
- Requester rules: a requester must hold req_data stable while valid & ~ready. It may drop valid at any time; dropping valid ends its grant.

Optional Feature:
- Macro: FIFO_WR_ARB_STAT_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_beats (Num_req*16).
  - stat_beats holds per-requester 16-bit saturating counts of accepted beats, cleared by srst or stat_clr.
  - If stat_clr and a beat coincide, the clear wins and the count becomes 0.
  - Saturation at 16'hFFFF.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single requester: req_valid=4'b0010 with 3 beats (0xA1, 0xA2, 0xA3), FIFO not full -> grant_id=1 one cycle after valid; 3 consecutive fifo_wr_en pulses with data A1, A2, A3; arb_busy falls after valid drops.
- All four requesters valid continuously, Burst_len=4 -> grant order 0,1,2,3,0; exactly 4 beats per grant; no idle cycle between grants.
- fifo_full forced high for 5 cycles mid-burst of requester 2 after 2 beats -> fifo_wr_en=0 and req_ready=0 for those 5 cycles; grant held; 2 more beats after full drops, then handover.
- FIFO depth 8 from empty, requester 0 streaming 20 beats -> exactly 8 writes accepted, then ready low while full; FIFO fifo_wr_err never asserts.
- srst pulsed during requester 3's second beat -> no write in the srst cycle; next cycle arb_busy=0, grant_id=0; next arbitration starts at requester 0.
- FIFO_WR_ARB_STAT_EN defined, 10 beats from requester 1 then stat_clr coinciding with 1 beat -> stat_beats[1] reads 10, then 0; the other counts stay 0.
